lake_cfg_sequencer: RTL and testbench
=====================================

LAKE_CFG_SEQUENCER -- requirements
Module: lake_cfg_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter CONFIG_MEMORY_SIZE SHALL default to 512 and is the width of the configuration vector driven to the datapath.
REQ-003 Parameter CFG_WORD_WIDTH SHALL default to 32 and is the width of one configuration bus word.
REQ-004 Parameter FLUSH_CYCLES SHALL default to 4 and is the number of cycles flush is held high; legal range is 1 to 255.
REQ-005 The block SHALL use NUM_WORDS = ceil(CONFIG_MEMORY_SIZE / CFG_WORD_WIDTH) as its word count (16 at the defaults).
REQ-006 clk  in  1  clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 cfg_start  in  1  single-cycle request to begin a configuration load.
REQ-009 cfg_data  in  CFG_WORD_WIDTH  configuration word.
REQ-010 cfg_valid  in  1  cfg_data is valid.
REQ-011 cfg_ready  out  1  the block accepts a word this cycle.
REQ-012 config_memory  out  CONFIG_MEMORY_SIZE  configuration vector to the datapath.
REQ-013 flush  out  1  datapath flush.
REQ-014 run  out  1  datapath enabled; the datapath's port valid/ready are gated with it.
REQ-015 busy  out  1  the block is in LOAD or FLUSH.
REQ-016 word_count  out  clog2(NUM_WORDS+2)  number of words accepted in the current load.
REQ-017 err  out  1  checksum error (see Configuration).

Function
REQ-018 The block SHALL implement four states: IDLE, LOAD, FLUSH and RUN, plus ERROR when CHECKSUM is enabled.
- All outputs are registered, except cfg_ready, which equals (state==LOAD).
REQ-019 From IDLE or RUN, cfg_start SHALL move the block to LOAD on the next edge and clear word_count to 0.
- run goes low in the same cycle that LOAD is entered.
REQ-020 In LOAD, a handshake (cfg_valid and cfg_ready) SHALL write cfg_data into shadow bits [k*CFG_WORD_WIDTH +: CFG_WORD_WIDTH], where k = word_count, and increment word_count.
- Bits of the last word beyond CONFIG_MEMORY_SIZE are discarded.
REQ-021 On the edge that completes the last handshake, config_memory SHALL take the shadow value atomically and the state SHALL become FLUSH.
- config_memory is never partially updated.
REQ-022 flush SHALL be high for exactly FLUSH_CYCLES consecutive cycles, starting with the first cycle in FLUSH; the block then moves to RUN with run=1.
REQ-023 cfg_start SHALL be ignored in LOAD and FLUSH; the load is not restarted.
REQ-024 Cycles with cfg_valid low in LOAD SHALL change nothing; a load has no timeout.
REQ-025 busy SHALL equal (state==LOAD or state==FLUSH).

Reset
REQ-026 Asserting rst_n low at any time, including mid-LOAD or mid-FLUSH, SHALL force IDLE and set the following to 0:
- config_memory, shadow, word_count;
- flush, run, busy, err.
REQ-027 After reset the block SHALL take no action until cfg_start is asserted.

Configuration
REQ-028 With macro LAKE_CFG_CHECKSUM_EN defined, LOAD SHALL accept NUM_WORDS+1 words; the final word is the XOR of the preceding NUM_WORDS words.
- Match: the block proceeds per REQ-021.
- Mismatch: the block enters ERROR with err=1, leaves config_memory unchanged and never asserts flush.
- cfg_start in ERROR clears err and enters LOAD.
REQ-029 Without LAKE_CFG_CHECKSUM_EN, no checksum word is accepted, the ERROR state does not exist and err SHALL be tied to 0.

Structure
REQ-030 Package lake_cfg_seq_pkg SHALL hold:
- the state enum typedef;
- the CFG_WORD_WIDTH default;
- the function computing NUM_WORDS.
REQ-031 The flush down-counter SHALL be a sub-module named lake_cfg_flush_timer, with inputs start and count and output active.

Verification
REQ-032 At defaults: cfg_start, then 16 back-to-back words with value k -> config_memory[32k+:32]=k after the 16th edge, flush high exactly 4 cycles, then run=1.
REQ-033 Same load with cfg_valid toggled every other cycle -> word_count advances only on handshakes; the final config_memory is identical.
REQ-034 rst_n pulsed low after 5 words -> IDLE with config_memory=0; a new full load succeeds.
REQ-035 In RUN with config A, cfg_start then load config B -> run=0 from the LOAD cycle; config_memory equals A until the 16th B word, then equals B.
REQ-036 CONFIG_MEMORY_SIZE=48 with words 0x11112222 and 0xAAAABBBB -> config_memory=0xBBBB11112222.
REQ-037 With LAKE_CFG_CHECKSUM_EN, 16 words plus a wrong checksum word -> err=1 and flush stays 0; the correct checksum -> normal flush and run.

Source files
------------

// File: rtl/lake_cfg_sequencer_pkg.sv
// Shared types and sizing helpers for the configuration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum (ERROR present only with LAKE_CFG_CHECKSUM_EN),
// default configuration word width, configuration word count function.
package lake_cfg_seq_pkg;

  localparam int DEF_CFG_WORD_WIDTH = 32;

`ifdef LAKE_CFG_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3
  } state_t;
`endif

  // Number of bus words needed to cover the configuration vector (ceiling).
  function automatic int num_words(input int mem_bits, input int word_bits);
    return (mem_bits + word_bits - 1) / word_bits;
  endfunction

endpackage

// File: rtl/lake_cfg_sequencer_if.sv
// Configuration word bus between a loader (master) and the sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: a word moves only on cycles where cfg_valid and cfg_ready are both high.
// Signals: cfg_start (load request), cfg_data/cfg_valid (word), cfg_ready (accept).
interface lake_cfg_sequencer_if #(
  parameter int W = 32
) ();
  logic         cfg_start;
  logic [W-1:0] cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;

  modport master (output cfg_start, output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_start, input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/lake_cfg_sequencer_flush_timer.sv
// Flush down-counter: loads count on start, then counts down to zero.
// Latency: active rises the cycle after start and stays high for count cycles.
// Backpressure: none; start reloads the counter unconditionally.
// Ports: clk, rst_n, start, count[7:0] in; active out (counter nonzero).
module lake_cfg_flush_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] count,
  output logic       active
);
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (start) begin
      cnt <= count;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign active = (cnt != 8'd0);
endmodule

// File: rtl/lake_cfg_sequencer.sv
// Loads a configuration vector word by word, commits it atomically, flushes, then runs.
// Latency: config_memory updates on the edge of the final handshake; flush follows for FLUSH_CYCLES, then run.
// Backpressure: cfg_ready is high only in LOAD; the loader may stall with cfg_valid low indefinitely.
// Ports: clk, rst_n; cfg (slave bus); config_memory, flush, run, busy, word_count, err.
// Optional feature macro: LAKE_CFG_CHECKSUM_EN (trailing XOR checksum word, ERROR state).
module lake_cfg_sequencer
  import lake_cfg_seq_pkg::*;
#(
  parameter int  CONFIG_MEMORY_SIZE = 512,
  parameter int  CFG_WORD_WIDTH     = DEF_CFG_WORD_WIDTH,
  parameter int  FLUSH_CYCLES       = 4,
  localparam int NUM_WORDS          = num_words(CONFIG_MEMORY_SIZE, CFG_WORD_WIDTH),
  localparam int WC_W               = $clog2(NUM_WORDS + 2)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  lake_cfg_sequencer_if.slave           cfg,
  output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
  output logic                          flush,
  output logic                          run,
  output logic                          busy,
  output logic [WC_W-1:0]               word_count,
  output logic                          err
);
  localparam int SHADOW_W = NUM_WORDS * CFG_WORD_WIDTH;

  state_t              state;
  logic [SHADOW_W-1:0] shadow;
  logic [SHADOW_W-1:0] shadow_nxt;
  logic                hs;
  logic                start_ok;
  logic                go_flush;
  logic                flush_more;

  assign cfg.cfg_ready = (state == ST_LOAD);
  assign hs            = cfg.cfg_valid && (state == ST_LOAD);

`ifdef LAKE_CFG_CHECKSUM_EN
  logic [CFG_WORD_WIDTH-1:0] chk_acc;
  logic                      chk_word;
  logic                      err_q;

  assign start_ok = cfg.cfg_start &&
                    (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);
  assign chk_word = (word_count == WC_W'(NUM_WORDS));
  assign go_flush = hs && chk_word && (cfg.cfg_data == chk_acc);
  assign err      = err_q;
`else
  assign start_ok = cfg.cfg_start && (state == ST_IDLE || state == ST_RUN);
  assign go_flush = hs && (word_count == WC_W'(NUM_WORDS - 1));
  assign err      = 1'b0;
`endif

  // Shadow with the current word merged in, so the final commit includes it.
  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (word_count == WC_W'(k)) begin
        shadow_nxt[k*CFG_WORD_WIDTH +: CFG_WORD_WIDTH] = cfg.cfg_data;
      end
    end
  end

  // The timer reports whether further flush cycles remain after the current
  // one, so it is loaded with one less than the flush length; this lets RUN
  // follow the last flush cycle with no gap.
  lake_cfg_flush_timer u_flush_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (go_flush),
    .count  (8'(FLUSH_CYCLES - 1)),
    .active (flush_more)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      shadow        <= '0;
      config_memory <= '0;
      word_count    <= '0;
      flush         <= 1'b0;
      run           <= 1'b0;
      busy          <= 1'b0;
`ifdef LAKE_CFG_CHECKSUM_EN
      chk_acc       <= '0;
      err_q         <= 1'b0;
`endif
    end else if (start_ok) begin
      state      <= ST_LOAD;
      word_count <= '0;
      run        <= 1'b0;
      busy       <= 1'b1;
`ifdef LAKE_CFG_CHECKSUM_EN
      chk_acc    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          if (hs) begin
            shadow     <= shadow_nxt;
            word_count <= word_count + WC_W'(1);
`ifdef LAKE_CFG_CHECKSUM_EN
            if (!chk_word) chk_acc <= chk_acc ^ cfg.cfg_data;
`endif
            if (go_flush) begin
              config_memory <= shadow_nxt[CONFIG_MEMORY_SIZE-1:0];
              flush         <= 1'b1;
              state         <= ST_FLUSH;
            end
`ifdef LAKE_CFG_CHECKSUM_EN
            else if (chk_word) begin
              // Bad checksum: keep the old configuration, never flush.
              err_q <= 1'b1;
              busy  <= 1'b0;
              state <= ST_ERROR;
            end
`endif
          end
        end
        ST_FLUSH: begin
          if (!flush_more) begin
            flush <= 1'b0;
            run   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lake_cfg_sequencer.sv
// Randomized scoreboard bench for lake_cfg_sequencer (default and 48-bit builds).
// Expected configurations are queued at load issue; a negedge monitor pops them
// when flush rises and checks flush length and the hand-off to run.
module tb_lake_cfg_sequencer;
  localparam int CMS = 512;
  localparam int W   = 32;
  localparam int NW  = 16;
  localparam int FC  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lake_cfg_sequencer_if #(.W(W)) bus ();
  logic [CMS-1:0] config_memory;
  logic           flush, run, busy, err;
  logic [4:0]     word_count;

  lake_cfg_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (bus.slave),
    .config_memory (config_memory),
    .flush         (flush),
    .run           (run),
    .busy          (busy),
    .word_count    (word_count),
    .err           (err)
  );

  lake_cfg_sequencer_if #(.W(W)) bus48 ();
  logic [47:0] cm48;
  logic        flush48, run48, busy48, err48;
  logic [1:0]  wc48;

  lake_cfg_sequencer #(.CONFIG_MEMORY_SIZE(48)) dut48 (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (bus48.slave),
    .config_memory (cm48),
    .flush         (flush48),
    .run           (run48),
    .busy          (busy48),
    .word_count    (wc48),
    .err           (err48)
  );

  int             checks   = 0;
  int             failures = 0;
  logic [CMS-1:0] exp_q[$];
  logic [CMS-1:0] cur_cfg;

  task automatic chk(input string name, input logic [CMS-1:0] act, input logic [CMS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: word k occupies bits [32k +: 32]; anything past CMS drops off.
  function automatic logic [CMS-1:0] pack_words(input logic [31:0] w[$]);
    logic [CMS-1:0] r = '0;
    for (int k = w.size() - 1; k >= 0; k--) r = (r << 32) | CMS'(w[k]);
    return r;
  endfunction

  function automatic logic [31:0] xor_words(input logic [31:0] w[$]);
    logic [31:0] x = '0;
    foreach (w[k]) x ^= w[k];
    return x;
  endfunction

  // Monitor / scoreboard.
  int fl_len  = 0;
  bit fl_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      fl_len  = 0;
      fl_prev = 1'b0;
    end else begin
      chk("ready_is_load", bus.cfg_ready, busy && !flush);
      chk("run_while_busy", run && busy, 0);
      if (flush && !fl_prev) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_flush actual=1 expected=0");
        end else begin
          chk("committed_cfg", config_memory, exp_q.pop_front());
        end
      end
      if (flush) fl_len++;
      if (!flush && fl_prev) begin
        chk("flush_len", fl_len, FC);
        chk("run_after_flush", run, 1);
`ifndef LAKE_CFG_CHECKSUM_EN
        chk("err_tied", err, 0);
`endif
        fl_len = 0;
      end
      fl_prev = flush;
    end
  end

  task automatic wait_run();
    for (int i = 0; i < 40 && !run; i++) begin
      @(posedge clk); #1;
    end
    chk("run_reached", run, 1);
  endtask

  // mode 0: back-to-back words k; 1: valid every other cycle, words k;
  // 2: random words/valid with stray cfg_start pulses.
  task automatic do_load(input int mode, input bit abort5, input bit bad_chk);
    logic [31:0]    w[$];
    logic [CMS-1:0] model;
    int             n  = 0;
    bit             ph = 1'b1;
    bit             v;
    for (int k = 0; k < NW; k++) w.push_back(mode < 2 ? 32'(k) : $urandom);
    model = pack_words(w);
    if (!abort5 && !bad_chk) exp_q.push_back(model);

    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    chk("load_run_low", run, 0);
    chk("load_busy", busy, 1);
    chk("load_wc_clear", word_count, 0);
    chk("load_err_clear", err, 0);

    while (n < NW) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
      ph = !ph;
      bus.cfg_valid = v;
      bus.cfg_data  = v ? w[n] : $urandom;
      if (mode == 2) bus.cfg_start = ($urandom_range(0, 7) == 0);
      chk("cfg_hold", config_memory, cur_cfg);
      @(posedge clk); #1;
      if (v) n++;
      bus.cfg_valid = 1'b0;
      bus.cfg_start = 1'b0;
      if (abort5 && n == 5) begin
        rst_n = 1'b0;
        #2;
        chk("rst_cfg", config_memory, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_run", run, 0);
        chk("rst_flush", flush, 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        cur_cfg = '0;
        repeat (3) begin @(posedge clk); #1; end
        chk("post_rst_idle", busy, 0);
        chk("post_rst_wc", word_count, 0);
        return;
      end
      chk("word_count", word_count, n);
    end

`ifdef LAKE_CFG_CHECKSUM_EN
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = bad_chk ? (xor_words(w) ^ 32'h1) : xor_words(w);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    chk("chk_word_count", word_count, NW + 1);
    if (bad_chk) begin
      chk("chk_err", err, 1);
      repeat (6) begin
        chk("chk_no_flush", flush, 0);
        @(posedge clk); #1;
      end
      chk("chk_cfg_kept", config_memory, cur_cfg);
      chk("chk_not_busy", busy, 0);
      return;
    end
`endif

    cur_cfg = model;
    if (mode == 2) begin
      bus.cfg_start = 1'b1;
      @(posedge clk); #1;
      bus.cfg_start = 1'b0;
    end
    wait_run();
    chk("final_cfg", config_memory, model);
    chk("final_busy", busy, 0);
  endtask

  initial begin
    logic [31:0] w48[$];
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
    bus48.cfg_start = 1'b0; bus48.cfg_valid = 1'b0; bus48.cfg_data = '0;
    cur_cfg = '0;
    #12;
    chk("reset_cfg", config_memory, 0);
    chk("reset_flags", {flush, run, busy, err, bus.cfg_ready}, 0);
    chk("reset_wc", word_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("idle_no_action", {busy, run, flush, bus.cfg_ready}, 0);

    do_load(0, 1'b0, 1'b0);
    do_load(1, 1'b0, 1'b0);
    do_load(2, 1'b0, 1'b0);
    do_load(2, 1'b1, 1'b0);
    do_load(0, 1'b0, 1'b0);
`ifdef LAKE_CFG_CHECKSUM_EN
    do_load(2, 1'b0, 1'b1);
    do_load(2, 1'b0, 1'b0);
`endif
    repeat (3) do_load(2, 1'b0, 1'b0);

    // 48-bit configuration: upper half of the second word is discarded.
    w48.push_back(32'h11112222);
    w48.push_back(32'hAAAABBBB);
    bus48.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus48.cfg_start = 1'b0;
    bus48.cfg_valid = 1'b1;
    foreach (w48[k]) begin
      bus48.cfg_data = w48[k];
      @(posedge clk); #1;
    end
`ifdef LAKE_CFG_CHECKSUM_EN
    bus48.cfg_data = xor_words(w48);
    @(posedge clk); #1;
`endif
    bus48.cfg_valid = 1'b0;
    for (int i = 0; i < 40 && !run48; i++) begin
      @(posedge clk); #1;
    end
    chk("cfg48_run", run48, 1);
    chk("cfg48_value", cm48, CMS'(48'(pack_words(w48))));

    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
